i2s_slave_port: RTL and testbench
=================================

Name: i2s_slave_port

Overview:
I2S target (slave) endpoint that is driven by an external I2S master. The master supplies BCLK, LRCLK and serial data. The block oversamples these pins in the system clock domain and deserialises the received left/right words. It also serialises a stereo pair back to the master, so it forms the codec-side counterpart of the master controller in the audio path.

Parameters:
DATA_WIDTH, 16, bits per channel word; MSB first.
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).
BIT_CNT_W, 6, width of the per-channel bit counter; must cover slot lengths up to 63 BCLKs.

Ports:
clk  in  1  system clock; must run at ≥8× BCLK.
rst  in  1  asynchronous, active-high reset.
i2s_bclk  in  1  bit clock from the master (asynchronous).
i2s_lrclk  in  1  word select from the master; 0 = left, 1 = right (asynchronous).
i2s_sdata_in  in  1  serial data from the master.
i2s_sdata_out  out  1  serial data to the master.
rx_data_left  out  DATA_WIDTH  last complete left word.
rx_data_right  out  DATA_WIDTH  last complete right word.
rx_valid  out  1  one-clk pulse when a new L+R pair is available.
tx_data_left  in  DATA_WIDTH  left word to transmit.
tx_data_right  in  DATA_WIDTH  right word to transmit.
tx_valid  in  1  TX pair offered.
tx_ready  out  1  TX holding register empty.
tx_underrun  out  1  one-clk pulse when a left frame starts with the holding register empty.
frame_err  out  1  one-clk pulse when LRCLK toggles before DATA_WIDTH bits have been received.

Behaviour:
- Reset: all outputs are 0 while rst is high, including tx_ready. The FSM enters ALIGN. In the first clk after deassertion, tx_ready goes to 1. A reset mid-frame discards all partial words and the holding register.
- Synchronisation: bclk, lrclk and sdata_in each pass through SYNC_STAGES flip-flops. A rising or falling edge of BCLK is the registered-versus-current compare of the synchronised bclk. All pin-side actions occur on these one-clk edge strobes.
- Rising-edge actions:
  - Sample lrclk into lr_s and sdata into the RX shift register.
  - If lr_s differs from lr_prev, a word boundary is detected: bit_cnt resets to 0 and the next rising edge carries the MSB (standard I2S one-bit delay).
  - Otherwise bit_cnt increments, saturating at all-ones.
  - Only bits with bit_cnt < DATA_WIDTH shift into the RX register; excess slot bits are ignored.
- FSM:
  - ALIGN→LEFT on the first detected 1→0 lrclk boundary. Nothing is captured or transmitted in ALIGN, and sdata_out is 0.
  - LEFT→RIGHT on the 0→1 boundary, latching the RX word into an internal left buffer.
  - RIGHT→LEFT on the 1→0 boundary: update rx_data_left from the buffer and rx_data_right from the RX word, then pulse rx_valid in the next clk.
  - Short word: if a boundary arrives with fewer than DATA_WIDTH bits received, pulse frame_err, drop that pair (no rx_valid) and go to ALIGN.
- TX holding:
  - When tx_valid && tx_ready, both words are latched and tx_ready drops in the next clk.
  - At each RIGHT→LEFT boundary the holding pair moves to the active pair, and tx_ready returns to 1 in the next clk.
  - If the holding register is empty at that boundary, pulse tx_underrun and load zeros as the active pair.
  - A tx_valid accepted in the same clk as the boundary transfer goes to the next frame.
- TX serialiser:
  - On each falling edge after a boundary, drive bit [DATA_WIDTH-1-n] of the active word for the current channel, where n = bits already sent.
  - Once n ≥ DATA_WIDTH, drive 0.
  - sdata_out changes only on falling-edge strobes.

Optional Feature:
I2S_UNDERRUN_REPEAT_EN
- Defined: on underrun, the previous active pair is retransmitted instead of zeros. tx_underrun still pulses.
- Undefined: zeros are transmitted, as described above.

Decomposition:
- Package i2s_pkg holds:
  - the state enum {ALIGN, LEFT, RIGHT};
  - channel constants CH_LEFT=0 and CH_RIGHT=1;
  - MIN_CLK_PER_BCLK=8.
- Sub-module i2s_sync_edge: SYNC_STAGES synchroniser plus rise/fall strobe generator. It is instantiated for bclk and, without edge outputs, for lrclk and sdata.

Test Plan:
- DATA_WIDTH=16, BCLK=clk/8, 16-bit slots, master sends L=0xA5C3, R=0x1234 → exactly one rx_valid pulse with rx_data_left=0xA5C3 and rx_data_right=0x1234, after alignment.
- Offer TX L=0xBEEF, R=0x0F0F before a left frame → master captures 0xBEEF/0x0F0F; tx_ready is 0 after acceptance and 1 one clk after the left boundary.
- No tx_valid for one frame → tx_underrun pulses once and the master captures 0x0000/0x0000; with the macro defined, it captures the prior pair again.
- 32-BCLK slots carrying L=0x8001, R=0x7FFE in the top 16 bits → RX words are correct, and TX bits 16–31 of each slot are 0.
- LRCLK toggles after 10 bits → frame_err pulse, no rx_valid; the next full L+R pair is received correctly after realignment.
- Assert rst for 3 clk mid-right-word → all outputs are 0; the first rx_valid appears only after a complete subsequent left+right pair.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// =============================================================================
// i2s_pkg : shared state encoding and channel constants for the I2S target port
// Rev 1.0
// =============================================================================
package i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int MIN_CLK_PER_BCLK = 8;

endpackage
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
// =============================================================================
// i2s_sync_edge : multi-stage input synchroniser with one-clk rise/fall strobes
// Rev 1.0
// =============================================================================
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2s_slave_port.sv
`default_nettype none
// =============================================================================
// i2s_slave_port : I2S target endpoint, oversampled RX deserialiser + TX serialiser
// Option macro: I2S_UNDERRUN_REPEAT_EN (resend previous pair on TX underrun)
// Rev 1.0
// =============================================================================
module i2s_slave_port #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int BIT_CNT_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2s_bclk,
  input  logic                  i2s_lrclk,
  input  logic                  i2s_sdata_in,
  output logic                  i2s_sdata_out,
  output logic [DATA_WIDTH-1:0] rx_data_left,
  output logic [DATA_WIDTH-1:0] rx_data_right,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data_left,
  input  logic [DATA_WIDTH-1:0] tx_data_right,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic                  frame_err
);
  import i2s_pkg::*;

  localparam logic [BIT_CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BIT_CNT_W-1:0] CNT_FULL = BIT_CNT_W'(DATA_WIDTH);
  localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);

  logic bclk_rise, bclk_fall, lr_in, sd_in;
  logic bclk_lvl_unused, lr_rise_unused, lr_fall_unused, sd_rise_unused, sd_fall_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk(clk), .rst(rst), .din(i2s_bclk),
    .dout(bclk_lvl_unused), .rise(bclk_rise), .fall(bclk_fall)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk(clk), .rst(rst), .din(i2s_lrclk),
    .dout(lr_in), .rise(lr_rise_unused), .fall(lr_fall_unused)
  );
  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdata_sync (
    .clk(clk), .rst(rst), .din(i2s_sdata_in),
    .dout(sd_in), .rise(sd_rise_unused), .fall(sd_fall_unused)
  );

  i2s_state_e            state_q, state_d;
  logic                  lr_s_q, lr_s_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d, left_buf_q, left_buf_d;
  logic [DATA_WIDTH-1:0] rx_left_q, rx_left_d, rx_right_q, rx_right_d;
  logic                  rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                  hold_full_q, hold_full_d, tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d, tx_sr_q, tx_sr_d;
  logic                  tx_underrun_q, tx_underrun_d, sdata_out_q, sdata_out_d;

  logic                  take_bit, boundary, word_ok;
  logic [DATA_WIDTH-1:0] rx_word;

  // The boundary rise still carries the LSB of the word that is ending.
  always_comb begin
    take_bit = bit_cnt_q < CNT_FULL;
    rx_word  = take_bit ? {rx_sr_q[DATA_WIDTH-2:0], sd_in} : rx_sr_q;
    boundary = bclk_rise && (lr_in != lr_s_q);
    word_ok  = bit_cnt_q >= CNT_LAST;
  end

  always_comb begin
    state_d       = state_q;
    lr_s_d        = lr_s_q;
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    left_buf_d    = left_buf_q;
    rx_left_d     = rx_left_q;
    rx_right_d    = rx_right_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    hold_l_d      = hold_l_q;
    hold_r_d      = hold_r_q;
    hold_full_d   = hold_full_q;
    act_l_d       = act_l_q;
    act_r_d       = act_r_q;
    tx_sr_d       = tx_sr_q;
    tx_underrun_d = 1'b0;
    sdata_out_d   = sdata_out_q;

    if (bclk_rise) begin
      lr_s_d = lr_in;
      if (boundary) begin
        bit_cnt_d = '0;
        rx_sr_d   = '0;
      end else begin
        rx_sr_d = rx_word;
        if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (boundary) begin
      case (state_q)
        ALIGN: begin
          if (lr_in == CH_LEFT) begin
            state_d = LEFT;
            tx_sr_d = act_l_q;
          end
        end
        LEFT: begin
          if (!word_ok) begin
            frame_err_d = 1'b1;
            state_d     = ALIGN;
          end else begin
            left_buf_d = rx_word;
            state_d    = RIGHT;
            tx_sr_d    = act_r_q;
          end
        end
        RIGHT: begin
          if (!word_ok) begin
            frame_err_d = 1'b1;
            state_d     = ALIGN;
          end else begin
            rx_left_d  = left_buf_q;
            rx_right_d = rx_word;
            rx_valid_d = 1'b1;
            state_d    = LEFT;
            if (hold_full_q) begin
              act_l_d     = hold_l_q;
              act_r_d     = hold_r_q;
              hold_full_d = 1'b0;
            end else begin
              tx_underrun_d = 1'b1;
`ifndef I2S_UNDERRUN_REPEAT_EN
              act_l_d = '0;
              act_r_d = '0;
`endif
            end
            tx_sr_d = act_l_d;
          end
        end
        default: state_d = ALIGN;
      endcase
    end

    // Acceptance after the transfer so a same-clk offer lands in the next frame.
    if (tx_valid && tx_ready_q) begin
      hold_l_d    = tx_data_left;
      hold_r_d    = tx_data_right;
      hold_full_d = 1'b1;
    end
    tx_ready_d = !hold_full_d;

    if (bclk_fall) begin
      sdata_out_d = (state_q == ALIGN) ? 1'b0 : tx_sr_q[DATA_WIDTH-1];
      tx_sr_d     = tx_sr_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ALIGN;
      lr_s_q        <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      left_buf_q    <= '0;
      rx_left_q     <= '0;
      rx_right_q    <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      hold_l_q      <= '0;
      hold_r_q      <= '0;
      hold_full_q   <= 1'b0;
      tx_ready_q    <= 1'b0;
      act_l_q       <= '0;
      act_r_q       <= '0;
      tx_sr_q       <= '0;
      tx_underrun_q <= 1'b0;
      sdata_out_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lr_s_q        <= lr_s_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      left_buf_q    <= left_buf_d;
      rx_left_q     <= rx_left_d;
      rx_right_q    <= rx_right_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      hold_l_q      <= hold_l_d;
      hold_r_q      <= hold_r_d;
      hold_full_q   <= hold_full_d;
      tx_ready_q    <= tx_ready_d;
      act_l_q       <= act_l_d;
      act_r_q       <= act_r_d;
      tx_sr_q       <= tx_sr_d;
      tx_underrun_q <= tx_underrun_d;
      sdata_out_q   <= sdata_out_d;
    end
  end

  assign i2s_sdata_out = sdata_out_q;
  assign rx_data_left  = rx_left_q;
  assign rx_data_right = rx_right_q;
  assign rx_valid      = rx_valid_q;
  assign tx_ready      = tx_ready_q;
  assign tx_underrun   = tx_underrun_q;
  assign frame_err     = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_slave_port.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// tb_i2s_slave_port : behavioural I2S master driving the target port, with
// queued expectations consumed by independent output monitors.
// Rev 1.0
// =============================================================================
module tb_i2s_slave_port;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  typedef struct packed {
    logic        chk;
    logic [15:0] l;
    logic [15:0] r;
  } txexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bclk = 1'b1;
  logic        lrclk = 1'b1;
  logic        sdin = 1'b0;
  logic        sdout;
  logic [15:0] rx_l, rx_r, tx_l, tx_r;
  logic        rx_valid, tx_valid, tx_ready, tx_underrun, frame_err;

  int checks = 0;
  int failures = 0;
  int cur_frame = -1;
  logic pend = 1'b0;

  pair_t  rx_q[$];
  txexp_t tx_q[$];
  int     unr_q[$];
  int     fe_q[$];

  i2s_slave_port #(.DATA_WIDTH(16), .SYNC_STAGES(2), .BIT_CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata_in(sdin), .i2s_sdata_out(sdout),
    .rx_data_left(rx_l), .rx_data_right(rx_r), .rx_valid(rx_valid),
    .tx_data_left(tx_l), .tx_data_right(tx_r), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One BCLK period: fall (drive), 4 clk low, rise, 4 clk high.
  task automatic period(input logic lr, input logic d);
    @(negedge clk);
    bclk = 1'b0; lrclk = lr; sdin = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_slot(input logic lr, input logic [15:0] w, input int slen);
    for (int k = 0; k < slen; k++) begin
      period(lr, pend);
      pend = (k < 16) ? w[15-k] : 1'b0;
    end
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    chk("tx_ready_before_offer", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1; tx_l = l; tx_r = r;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_after_accept", 32'(tx_ready), 32'd0);
  endtask

  // Pulse monitors.
  pair_t rx_e;
  int    unr_e, fe_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) chk("rx_valid_unexpected", 32'({rx_l, rx_r}), 32'h0);
        else begin
          rx_e = rx_q.pop_front();
          chk("rx_left", 32'(rx_l), 32'(rx_e.l));
          chk("rx_right", 32'(rx_r), 32'(rx_e.r));
        end
      end
      if (tx_underrun) begin
        if (unr_q.size() == 0) chk("tx_underrun_unexpected", 32'(cur_frame), 32'hFFFF_FFFF);
        else begin
          unr_e = unr_q.pop_front();
          chk("tx_underrun_frame", 32'(cur_frame), 32'(unr_e));
        end
      end
      if (frame_err) begin
        if (fe_q.size() == 0) chk("frame_err_unexpected", 32'(cur_frame), 32'hFFFF_FFFF);
        else begin
          fe_e = fe_q.pop_front();
          chk("frame_err_frame", 32'(cur_frame), 32'(fe_e));
        end
      end
    end
  end

  // Master-side capture of sdata_out (one-bit delayed I2S framing).
  logic        m_lr_prev = 1'b1;
  bit          m_have_left = 1'b0;
  logic [15:0] m_word = '0, m_left = '0;
  int          m_cnt = 0;
  bit          m_extra = 1'b0, m_extra_l = 1'b0;
  txexp_t      tx_e;

  task automatic m_take(input logic s);
    if (m_cnt < 16) m_word = {m_word[14:0], s};
    else if (s) m_extra = 1'b1;
    m_cnt++;
  endtask

  always @(posedge bclk) begin
    m_take(sdout);
    if (lrclk != m_lr_prev) begin
      if (m_lr_prev == 1'b0) begin
        m_left = m_word; m_extra_l = m_extra; m_have_left = 1'b1;
      end else if (m_have_left) begin
        m_have_left = 1'b0;
        if (tx_q.size() == 0) chk("tx_pair_unexpected", 32'({m_left, m_word}), 32'h0);
        else begin
          tx_e = tx_q.pop_front();
          if (tx_e.chk) begin
            chk("tx_left", 32'(m_left), 32'(tx_e.l));
            chk("tx_right", 32'(m_word), 32'(tx_e.r));
            chk("tx_pad_zero", 32'(m_extra_l | m_extra), 32'd0);
          end
        end
      end
      m_word = '0; m_cnt = 0; m_extra = 1'b0;
      m_lr_prev = lrclk;
    end
  end

  initial begin
    tx_valid = 1'b0; tx_l = '0; tx_r = '0;
    repeat (4) @(negedge clk);
    chk("reset_flags", 32'({rx_valid, tx_ready, sdout, tx_underrun, frame_err}), 32'd0);
    chk("reset_rx_data", {rx_l, rx_r}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("tx_ready_after_reset", 32'(tx_ready), 32'd1);

    send_slot(1'b1, 16'hFFFF, 16);

    cur_frame = 0;
    rx_q.push_back({16'hA5C3, 16'h1234});
    tx_q.push_back({1'b1, 16'h0000, 16'h0000});
    send_slot(1'b0, 16'hA5C3, 16);
    offer(16'hBEEF, 16'h0F0F);
    send_slot(1'b1, 16'h1234, 16);
    chk("tx_ready_held_before_boundary", 32'(tx_ready), 32'd0);

    cur_frame = 1;
    rx_q.push_back({16'h1111, 16'h2222});
    tx_q.push_back({1'b1, 16'hBEEF, 16'h0F0F});
    send_slot(1'b0, 16'h1111, 16);
    chk("tx_ready_after_transfer", 32'(tx_ready), 32'd1);
    send_slot(1'b1, 16'h2222, 16);

    cur_frame = 2;
    unr_q.push_back(2);
    rx_q.push_back({16'h3333, 16'h4444});
`ifdef I2S_UNDERRUN_REPEAT_EN
    tx_q.push_back({1'b1, 16'hBEEF, 16'h0F0F});
`else
    tx_q.push_back({1'b1, 16'h0000, 16'h0000});
`endif
    send_slot(1'b0, 16'h3333, 16);
    offer(16'h1357, 16'h9BDF);
    send_slot(1'b1, 16'h4444, 16);

    cur_frame = 3;
    rx_q.push_back({16'h8001, 16'h7FFE});
    tx_q.push_back({1'b1, 16'h1357, 16'h9BDF});
    send_slot(1'b0, 16'h8001, 32);
    offer(16'hCAFE, 16'hF00D);
    send_slot(1'b1, 16'h7FFE, 32);

    cur_frame = 4;
    fe_q.push_back(4);
    tx_q.push_back({1'b0, 16'h0000, 16'h0000});
    send_slot(1'b0, 16'hFFFF, 10);
    send_slot(1'b1, 16'hAAAA, 16);

    cur_frame = 5;
    rx_q.push_back({16'h5A5A, 16'hC3C3});
    tx_q.push_back({1'b1, 16'hCAFE, 16'hF00D});
    send_slot(1'b0, 16'h5A5A, 16);
    send_slot(1'b1, 16'hC3C3, 16);

    cur_frame = 6;
    unr_q.push_back(6);
    tx_q.push_back({1'b0, 16'h0000, 16'h0000});
    send_slot(1'b0, 16'h6666, 16);
    fork
      send_slot(1'b1, 16'h7777, 16);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("in_reset_flags", 32'({rx_valid, tx_ready, sdout, tx_underrun, frame_err}), 32'd0);
        end
        chk("in_reset_rx_data", {rx_l, rx_r}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("tx_ready_after_midframe_reset", 32'(tx_ready), 32'd1);
      end
    join

    cur_frame = 7;
    rx_q.push_back({16'hABCD, 16'h4321});
    tx_q.push_back({1'b1, 16'h0000, 16'h0000});
    send_slot(1'b0, 16'hABCD, 16);
    send_slot(1'b1, 16'h4321, 16);

    cur_frame = 8;
    unr_q.push_back(8);
    send_slot(1'b0, 16'h0000, 2);
    repeat (20) @(negedge clk);

    chk("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    chk("underrun_queue_drained", 32'(unr_q.size()), 32'd0);
    chk("frame_err_queue_drained", 32'(fe_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
